led_fader: RTL and testbench
============================

LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter NUM_LEDS, default 8: number of LED channels.
REQ-002 Parameter PWM_BITS, default 8: width of the PWM counter and of each brightness level.
REQ-003 Parameter DECAY_DIV, default 65536: clock cycles per decay tick; legal range 1 to 2^24.
REQ-004 Parameter DECAY_STEP, default 16: brightness subtracted per decay tick; legal range 1 to 2^PWM_BITS-1.
REQ-005 Port clk, input, 1: single system clock; all state SHALL be clocked on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous reset, active-low.
REQ-007 Port leds_in, input, NUM_LEDS: LED drive from the sequencer stage, synchronous to clk, any bit pattern legal.
REQ-008 Port leds_out, output, NUM_LEDS: registered PWM drive to the board LEDs, 1 = lit.

Function
REQ-009 A free-running PWM counter pwm_cnt SHALL increment every cycle, wrapping from 2^PWM_BITS-1 to 0.
REQ-010 A prescaler SHALL assert a one-cycle decay tick once every DECAY_DIV cycles; with DECAY_DIV=1, tick SHALL be asserted every cycle.
REQ-011 Each channel i SHALL hold level[i] (PWM_BITS wide).
REQ-012 If leds_in[i]=1 at a clock edge, level[i] SHALL load 2^PWM_BITS-1.
REQ-013 Else if tick=1, level[i] SHALL become level[i]-DECAY_STEP, saturating at 0 (never wraps).
REQ-014 Else level[i] SHALL hold.
REQ-015 Simultaneous leds_in[i]=1 and tick: load wins; no decrement that cycle.
REQ-016 leds_out[i] SHALL be registered as leds_in[i] OR (eff[i] > pwm_cnt), using values present before the edge.
REQ-017 eff[i] SHALL equal level[i] without the gamma feature (see Configuration).
REQ-018 Latency: leds_in[i] rising at edge k SHALL give leds_out[i]=1 after edge k (one cycle); input-high forces output steady on.
REQ-019 level[i]=0 SHALL give leds_out[i]=0 for every pwm_cnt unless leds_in[i]=1.
REQ-020 Channels SHALL be independent; multiple high bits in leds_in SHALL be handled per channel.

Reset
REQ-021 While rst_n=0: pwm_cnt=0, prescaler=0, every level[i]=0, leds_out=0, asserted asynchronously.
REQ-022 After rst_n deasserts, the first tick SHALL occur DECAY_DIV cycles later.
REQ-023 Reset mid-fade SHALL discard all brightness; no residual glow after release.

Configuration
REQ-024 Macro LED_FADER_GAMMA_EN: when defined, eff[i] SHALL be (level[i]*level[i]) >> PWM_BITS, giving a perceptual fade curve.
REQ-025 When LED_FADER_GAMMA_EN is undefined, eff[i]=level[i]; no multiplier logic SHALL be present.
REQ-026 Output latency and reset behaviour SHALL be identical with and without the macro.

Structure
REQ-027 Package led_pkg SHALL hold NUM_LEDS default, PWM_BITS default, and a level_t typedef of PWM_BITS width.
REQ-028 Sub-module led_fader_channel SHALL implement level register, saturation, gamma and compare for one channel; led_fader SHALL instantiate NUM_LEDS copies.
REQ-029 pwm_cnt and prescaler SHALL be shared across channels, not per channel.

Verification
Bench parameters for all scenarios: DECAY_DIV=4, DECAY_STEP=64, PWM_BITS=8, gamma off unless stated.
REQ-030 Reset: rst_n=0 mid-run with levels nonzero -> leds_out=0 immediately; all levels read 0 after release.
REQ-031 Load and decay: leds_in=8'h01 for 1 cycle -> level[0]=255, then 191, 127, 63, 0 on successive ticks, holding at 0.
REQ-032 PWM duty: level[0] held at 127 -> leds_out[0] high exactly 127 of every 256 cycles.
REQ-033 Collision: leds_in[3]=1 on a tick cycle -> level[3]=255, not 191.
REQ-034 Walking one-hot input 8'h01 -> 8'h02 -> 8'h04, advancing every 8 cycles -> previous LED fades while new LED is forced on; no channel crosstalk.
REQ-035 Gamma on: level=128 -> eff=64; leds_out high 64 of every 256 cycles.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared defaults and level type for the LED fader
package led_pkg;

  localparam int NUM_LEDS_DEF = 8;
  localparam int PWM_BITS_DEF = 8;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

endpackage

// File: rtl/led_fader_channel.sv
// rtl/led_fader_channel.sv - one LED channel: brightness level, saturating decay, optional gamma (LED_FADER_GAMMA_EN), PWM compare
module led_fader_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                led_in,
  output logic                led_out
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_nxt;
  logic [PWM_BITS-1:0] eff;

  // Load wins over decay; decay floors at zero instead of wrapping.
  always_comb begin
    level_nxt = level;
    if (led_in) begin
      level_nxt = LEVEL_MAX;
    end else if (tick) begin
      level_nxt = (level > STEP) ? (level - STEP) : '0;
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  assign level_sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
  assign eff      = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign eff = level;
`endif

  // Level register and registered PWM output, both built from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      level   <= level_nxt;
      led_out <= led_in | (eff > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - multi-channel LED fader with shared PWM counter and decay prescaler; gamma curve via LED_FADER_GAMMA_EN
module led_fader
  import led_pkg::*;
#(
  parameter int NUM_LEDS   = NUM_LEDS_DEF,
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_DIV  = 65536,
  parameter int DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_LEDS-1:0] leds_in,
  output logic [NUM_LEDS-1:0] leds_out
);

  // A one-bit prescaler still works for DECAY_DIV=1: it sits at 0 == DIV_MAX.
  localparam int               DIV_W   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DECAY_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    presc;
  logic                tick;

  assign tick = (presc == DIV_MAX);

  // Free-running PWM ramp shared by every channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Prescaler counts 0..DECAY_DIV-1 so the first tick lands DECAY_DIV cycles after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : gen_ch
    led_fader_channel #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .pwm_cnt(pwm_cnt),
      .led_in (leds_in[i]),
      .led_out(leds_out[i])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - directed self-checking bench for led_fader (expectations adapt to LED_FADER_GAMMA_EN)
module tb_led_fader;

  logic       clk;
  logic       rst_n;
  logic [7:0] leds_in;
  logic [7:0] leds_out;
  logic [0:0] d_in;
  logic [0:0] d_out;
  logic [0:0] g_out;

  int checks;
  int failures;
  int n;
  int cnt_d;
  int cnt_g;

`ifdef LED_FADER_GAMMA_EN
  localparam int EXP_FULL = 254;
  localparam int EXP_D127 = 63;
  localparam int EXP_G128 = 64;
  localparam int EXP_G1   = 0;
`else
  localparam int EXP_FULL = 255;
  localparam int EXP_D127 = 127;
  localparam int EXP_G128 = 128;
  localparam int EXP_G1   = 1;
`endif

  led_fader #(
    .NUM_LEDS(8), .PWM_BITS(8), .DECAY_DIV(4), .DECAY_STEP(64)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .leds_in(leds_in), .leds_out(leds_out)
  );

  // Slow-decay instances hold a level long enough to measure PWM duty.
  led_fader #(
    .NUM_LEDS(1), .PWM_BITS(8), .DECAY_DIV(1024), .DECAY_STEP(128)
  ) u_d (
    .clk(clk), .rst_n(rst_n), .leds_in(d_in), .leds_out(d_out)
  );

  led_fader #(
    .NUM_LEDS(1), .PWM_BITS(8), .DECAY_DIV(1024), .DECAY_STEP(127)
  ) u_g (
    .clk(clk), .rst_n(rst_n), .leds_in(d_in), .leds_out(g_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic step_to(input int target);
    while (n < target) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n        = 0;
    rst_n    = 1'b0;
    leds_in  = 8'h00;
    d_in     = 1'b0;

    // Reset state
    #12;
    check("reset_leds_out", int'(leds_out), 0);
    check("reset_level0", int'(u_main.gen_ch[0].u_ch.level), 0);
    check("reset_level7", int'(u_main.gen_ch[7].u_ch.level), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;

    // Load and decay on channel 0
    leds_in = 8'h01;
    step();
    check("load_level0", int'(u_main.gen_ch[0].u_ch.level), 255);
    check("load_out0", int'(leds_out[0]), 1);
    check("load_other_levels", int'(u_main.gen_ch[1].u_ch.level), 0);
    leds_in = 8'h00;
    step_to(3);
    check("hold_before_tick", int'(u_main.gen_ch[0].u_ch.level), 255);
    step_to(4);
    check("decay_191", int'(u_main.gen_ch[0].u_ch.level), 191);
    step_to(8);
    check("decay_127", int'(u_main.gen_ch[0].u_ch.level), 127);
    step_to(12);
    check("decay_63", int'(u_main.gen_ch[0].u_ch.level), 63);
    step_to(16);
    check("decay_sat0", int'(u_main.gen_ch[0].u_ch.level), 0);
    step_to(20);
    check("decay_hold0", int'(u_main.gen_ch[0].u_ch.level), 0);
    check("dark_out0", int'(leds_out[0]), 0);

    // Collision: input held high across a tick edge
    step_to(22);
    leds_in = 8'h08;
    step();
    check("coll_load3", int'(u_main.gen_ch[3].u_ch.level), 255);
    step();
    check("coll_tick3", int'(u_main.gen_ch[3].u_ch.level), 255);
    leds_in = 8'h00;
    step_to(28);
    check("coll_next_tick3", int'(u_main.gen_ch[3].u_ch.level), 191);
    check("coll_ch0_still0", int'(u_main.gen_ch[0].u_ch.level), 0);

    // Walking one-hot, 8 cycles per position
    do_reset();
    leds_in = 8'h01;
    for (int k = 0; k < 8; k++) begin
      step();
      check("walk0_on", int'(leds_out[0]), 1);
      check("walk0_quiet", int'(leds_out[7:3]), 0);
    end
    check("walk0_lvl0", int'(u_main.gen_ch[0].u_ch.level), 255);
    leds_in = 8'h02;
    for (int k = 0; k < 8; k++) begin
      step();
      check("walk1_on", int'(leds_out[1]), 1);
      check("walk1_quiet", int'(leds_out[7:3]), 0);
    end
    check("walk1_lvl0", int'(u_main.gen_ch[0].u_ch.level), 127);
    check("walk1_lvl1", int'(u_main.gen_ch[1].u_ch.level), 255);
    leds_in = 8'h04;
    for (int k = 0; k < 8; k++) begin
      step();
      check("walk2_on", int'(leds_out[2]), 1);
      check("walk2_quiet", int'(leds_out[7:3]), 0);
    end
    check("walk2_lvl0", int'(u_main.gen_ch[0].u_ch.level), 0);
    check("walk2_lvl1", int'(u_main.gen_ch[1].u_ch.level), 127);
    check("walk2_lvl2", int'(u_main.gen_ch[2].u_ch.level), 255);
    check("walk2_lvl5", int'(u_main.gen_ch[5].u_ch.level), 0);

    // Reset mid-fade clears outputs asynchronously and leaves no glow
    leds_in = 8'h00;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_out", int'(leds_out), 0);
    check("midrst_lvl1", int'(u_main.gen_ch[1].u_ch.level), 0);
    check("midrst_lvl2", int'(u_main.gen_ch[2].u_ch.level), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("postrst_out", int'(leds_out), 0);
    end
    check("postrst_lvl2", int'(u_main.gen_ch[2].u_ch.level), 0);

    // PWM duty measurement on the slow-decay instances
    do_reset();
    d_in = 1'b1;
    step();
    d_in = 1'b0;
    cnt_d = 0;
    cnt_g = 0;
    repeat (256) begin
      step();
      cnt_d += int'(d_out);
      cnt_g += int'(g_out);
    end
    check("duty_full_d", cnt_d, EXP_FULL);
    check("duty_full_g", cnt_g, EXP_FULL);

    step_to(1024);
    check("slow_lvl_d127", int'(u_d.gen_ch[0].u_ch.level), 127);
    check("slow_lvl_g128", int'(u_g.gen_ch[0].u_ch.level), 128);
    cnt_d = 0;
    cnt_g = 0;
    repeat (256) begin
      step();
      cnt_d += int'(d_out);
      cnt_g += int'(g_out);
    end
    check("duty_127", cnt_d, EXP_D127);
    check("duty_128", cnt_g, EXP_G128);

    step_to(2048);
    check("slow_lvl_d_sat", int'(u_d.gen_ch[0].u_ch.level), 0);
    check("slow_lvl_g1", int'(u_g.gen_ch[0].u_ch.level), 1);
    cnt_d = 0;
    cnt_g = 0;
    repeat (256) begin
      step();
      cnt_d += int'(d_out);
      cnt_g += int'(g_out);
    end
    check("duty_zero", cnt_d, 0);
    check("duty_1", cnt_g, EXP_G1);

    step_to(3072);
    check("slow_lvl_g_sat", int'(u_g.gen_ch[0].u_ch.level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
